// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions and arbiter state type for the ALU-sharing
// arbiter and its datapath.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 3'b000;
    localparam alu_op_t ALU_OR   = 3'b001;
    localparam alu_op_t ALU_ADD  = 3'b010;
    localparam alu_op_t ALU_ANDN = 3'b100;
    localparam alu_op_t ALU_ORN  = 3'b101;
    localparam alu_op_t ALU_SUB  = 3'b110;
    localparam alu_op_t ALU_SLT  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic [NREQ-1:0][2:0]  req_f;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [31:0]           rsp_y;
    logic                  rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_f, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_f, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_zero
    );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU: F[2] inverts B (and supplies the carry-in),
// F[1:0] selects AND / OR / SUM / set-less-than.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     f,
    output logic [31:0] y,
    output logic        zero
);
    logic [31:0] bb;
    logic [31:0] sum;
    logic        lt;

    always_comb begin
        bb  = f[2] ? ~b : b;
        sum = a + bb + {31'd0, f[2]};
        // Signed compare that stays correct when a - b overflows.
        lt  = (a[31] != b[31]) ? a[31] : sum[31];
        unique case (f[1:0])
            2'b00:   y = a & bb;
            2'b01:   y = a | bb;
            2'b10:   y = sum;
            default: y = {31'd0, lt};
        endcase
        zero = (y == 32'd0);
    end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: lowest offset from ptr whose
// valid bit is set wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0][IW-1:0] cand;
    logic [N-1:0]         hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            logic [IW:0] wrapped;
            assign sum        = {1'b0, ptr} + (IW+1)'(gi);
            assign wrapped    = sum - (IW+1)'(N);
            assign cand[gi]   = (sum >= (IW+1)'(N)) ? wrapped[IW-1:0] : sum[IW-1:0];
            assign hit[gi]    = valid[cand[gi]];
            assign grant[gi]  = any && (idx == IW'(gi));
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters;
// results are registered and held until the owning requester consumes them.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    arb_state_t      state_reg, state_next;
    logic [IDW-1:0]  owner_reg, owner_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [31:0]     rsp_y_reg, rsp_y_next;
    logic            rsp_zero_reg, rsp_zero_next;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            can_issue;
    logic            accept;
    logic [NREQ-1:0] req_ready_vec;
    logic [NREQ-1:0] rsp_valid_vec;

    logic [31:0]     alu_a, alu_b, alu_y;
    alu_op_t         alu_f;
    logic            alu_zero;

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign alu_a = bus.req_a[pick_idx];
    assign alu_b = bus.req_b[pick_idx];
    assign alu_f = bus.req_f[pick_idx];

    alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .f    (alu_f),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        rsp_y_next    = rsp_y_reg;
        rsp_zero_next = rsp_zero_reg;

        // A held result frees the ALU slot in the same cycle it is consumed.
        can_issue     = (state_reg == ST_IDLE) || bus.rsp_ready[owner_reg];
        accept        = !reset && can_issue && pick_any;
        req_ready_vec = accept ? pick_grant : '0;

        if (accept) begin
            state_next    = ST_HOLD;
            owner_next    = pick_idx;
            rsp_y_next    = alu_y;
            rsp_zero_next = alu_zero;
            rr_ptr_next   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if ((state_reg == ST_HOLD) && bus.rsp_ready[owner_reg]) begin
            state_next = ST_IDLE;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp_valid
            assign rsp_valid_vec[gi] = (state_reg == ST_HOLD) && (owner_reg == IDW'(gi));
        end
    endgenerate

    assign bus.req_ready = req_ready_vec;
    assign bus.rsp_valid = rsp_valid_vec;
    assign bus.rsp_y     = rsp_y_reg;
    assign bus.rsp_zero  = rsp_zero_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            rsp_y_reg    <= 32'd0;
            rsp_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            rsp_y_reg    <= rsp_y_next;
            rsp_zero_reg <= rsp_zero_next;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand sequences
// for the multi-cycle cases, and randomized traffic against a behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ)) bus ();

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     f;
        logic [31:0] y;
        logic        z;
    } vec_t;

    vec_t    tbl [11];
    alu_op_t fl  [7];
    int      order [6];

    int checks = 0;
    int errors = 0;
    int last_grant;

    // Behavioural model: one result slot, an owner and a fairness pointer.
    bit          m_held;
    int          m_owner;
    int          m_ptr;
    logic [31:0] m_y;
    logic        m_z;
    bit          m_cleared;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input alu_op_t f);
        case (f)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_ANDN: return a & ~b;
            ALU_ORN:  return a | ~b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called shortly after a rising edge with the inputs for this cycle driven.
    task automatic cycle();
        int              g;
        bit              can;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rv;
        logic [NREQ-1:0] rr;
        logic [31:0]     ga, gb;
        alu_op_t         gf;
        bit              rst;
        #1;
        can = !m_held || (bus.rsp_ready[m_owner] == 1'b1);
        g = -1;
        if (!reset && can) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = '0;
        if (m_held) exp_rv[m_owner] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (m_held || m_cleared) begin
            chk("rsp_y", bus.rsp_y, m_y);
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(m_z));
        end
        last_grant = g;
        rr  = bus.rsp_ready;
        rst = reset;
        ga = 32'd0; gb = 32'd0; gf = ALU_AND;
        if (g >= 0) begin
            ga = bus.req_a[g];
            gb = bus.req_b[g];
            gf = bus.req_f[g];
        end
        @(posedge clk);
        if (rst) begin
            m_held = 0; m_owner = 0; m_ptr = 0; m_y = 32'd0; m_z = 1'b0; m_cleared = 1;
        end else if (g >= 0) begin
            m_y       = ref_alu(ga, gb, gf);
            m_z       = (m_y == 32'd0);
            m_owner   = g;
            m_held    = 1;
            m_ptr     = (g + 1) % NREQ;
            m_cleared = 0;
            $display("accept req=%0d a=%h b=%h f=%0d -> y=%h zero=%0d", g, ga, gb, gf, m_y, m_z);
        end else if (m_held && rr[m_owner]) begin
            m_held = 0;
        end
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input alu_op_t f);
        bus.req_a[r] = a;
        bus.req_b[r] = b;
        bus.req_f[r] = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'd5,        32'd7,        ALU_ADD,  32'd12,       1'b0};
        tbl[1]  = '{32'hFFFFFFFF, 32'd1,        ALU_ADD,  32'd0,        1'b1};
        tbl[2]  = '{32'h0000F0F0, 32'h0000FF00, ALU_AND,  32'h0000F000, 1'b0};
        tbl[3]  = '{32'h0000F0F0, 32'h00000F0F, ALU_OR,   32'h0000FFFF, 1'b0};
        tbl[4]  = '{32'hFFFF0000, 32'hFFFF0000, ALU_ANDN, 32'd0,        1'b1};
        tbl[5]  = '{32'd0,        32'hFFFFFFFE, ALU_ORN,  32'd1,        1'b0};
        tbl[6]  = '{32'd10,       32'd3,        ALU_SUB,  32'd7,        1'b0};
        tbl[7]  = '{32'h80000000, 32'd1,        ALU_SLT,  32'd1,        1'b0};
        tbl[8]  = '{32'h7FFFFFFF, 32'h80000000, ALU_SLT,  32'd0,        1'b1};
        tbl[9]  = '{32'd3,        32'd9,        ALU_SLT,  32'd1,        1'b0};
        tbl[10] = '{32'd5,        32'd5,        ALU_SLT,  32'd0,        1'b1};
        fl[0] = ALU_AND; fl[1] = ALU_OR;  fl[2] = ALU_ADD; fl[3] = ALU_ANDN;
        fl[4] = ALU_ORN; fl[5] = ALU_SUB; fl[6] = ALU_SLT;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0; order[5] = 1;

        reset = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = '0;
        for (int r = 0; r < NREQ; r++) set_req(r, 32'd1, 32'd1, ALU_ADD);
        repeat (2) @(posedge clk);
        #1;
        m_held = 0; m_owner = 0; m_ptr = 0; m_y = 32'd0; m_z = 1'b0; m_cleared = 1;

        // Reset state with every requester asking: nothing may be granted.
        cycle();
        reset = 1'b0;
        bus.req_valid = '0;
        cycle();

        // Single request, same-cycle ready, one-cycle latency, release.
        set_req(0, 32'd5, 32'd7, ALU_ADD);
        bus.req_valid = 4'b0001;
        cycle();
        chk("single_grant", 32'(last_grant), 32'd0);
        bus.req_valid = '0;
        chk("single_y", bus.rsp_y, 32'd12);
        chk("single_zero", 32'(bus.rsp_zero), 32'd0);
        chk("single_rv", 32'(bus.rsp_valid), 32'h1);
        bus.rsp_ready = 4'b0001;
        cycle();
        bus.rsp_ready = '0;
        chk("single_release", 32'(bus.rsp_valid), 32'h0);

        // Zero flag, then SLT back-to-back on the same requester.
        set_req(2, 32'h1234, 32'h1234, ALU_SUB);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = '1;
        cycle();
        chk("zero_y", bus.rsp_y, 32'd0);
        chk("zero_flag", 32'(bus.rsp_zero), 32'd1);
        set_req(2, 32'd3, 32'd9, ALU_SLT);
        cycle();
        bus.req_valid = '0;
        chk("slt_y", bus.rsp_y, 32'd1);
        chk("slt_flag", 32'(bus.rsp_zero), 32'd0);
        cycle();

        // Directed vector table, rotating across requesters.
        for (int i = 0; i < 11; i++) begin
            int r;
            r = i % NREQ;
            set_req(r, tbl[i].a, tbl[i].b, tbl[i].f);
            bus.req_valid = '0;
            bus.req_valid[r] = 1'b1;
            cycle();
            bus.req_valid = '0;
            chk("vec_y", bus.rsp_y, tbl[i].y);
            chk("vec_zero", 32'(bus.rsp_zero), 32'(tbl[i].z));
        end
        cycle();

        // Contention from a fresh pointer: strict rotation, one accept per cycle.
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, 32'(r * 100 + 1), 32'(r + 1000), ALU_ADD);
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        for (int n = 0; n < 6; n++) begin
            cycle();
            chk("rr_order", 32'(last_grant), 32'(order[n]));
            chk("rr_sum", bus.rsp_y, 32'(order[n] * 100 + 1 + order[n] + 1000));
        end
        bus.req_valid = '0;
        cycle();

        // Backpressure: result for requester 1 held while requester 3 waits.
        set_req(1, 32'h00ABCDEF, 32'h00000011, ALU_OR);
        set_req(3, 32'd40, 32'd2, ALU_ADD);
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0010;
        cycle();
        bus.req_valid = 4'b1000;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_y", bus.rsp_y, 32'h00ABCDFF);
        end
        bus.rsp_ready = 4'b0010;
        cycle();
        chk("bp_grant", 32'(last_grant), 32'd3);
        bus.rsp_ready = '0;
        bus.req_valid = '0;
        chk("bp_rv", 32'(bus.rsp_valid), 32'h8);
        chk("bp_y3", bus.rsp_y, 32'd42);
        bus.rsp_ready = '1;
        cycle();

        // Non-owner ready must not release the held result.
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 4'b0001;
        cycle();
        bus.req_valid = '0;
        repeat (2) cycle();
        chk("nonowner_rv", 32'(bus.rsp_valid), 32'h2);

        // Reset while holding discards the result and restarts the pointer.
        do_reset();
        chk("rst_rv", 32'(bus.rsp_valid), 32'h0);
        chk("rst_y", bus.rsp_y, 32'd0);
        chk("rst_zero", 32'(bus.rsp_zero), 32'd0);
        bus.req_valid = 4'b1010;
        cycle();
        chk("rst_grant", 32'(last_grant), 32'd1);
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        cycle();

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                logic [31:0] a;
                logic [31:0] b;
                a = $urandom;
                b = ($urandom_range(0, 5) == 0) ? a : $urandom;
                set_req(r, a, b, fl[$urandom_range(0, 6)]);
            end
            bus.req_valid = NREQ'($urandom);
            bus.rsp_ready = NREQ'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 1'b0;
        bus.req_valid = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` (32-bit A/B, 3-bit F, outputs Y and Zero) between NREQ requesters, for example the integer pipe, the branch-compare unit and the address-generation helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Results are registered and returned one cycle after acceptance.
- Sustains one operation per cycle when responses are consumed immediately.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the grant/owner index. Derived; do not override.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i presents an operation
- req_ready  out  NREQ  operation of requester i accepted this cycle (at most one bit set)
- req_a  in  NREQ x 32  operand A per requester
- req_b  in  NREQ x 32  operand B per requester
- req_f  in  NREQ x 3  ALU function per requester (000 AND, 001 OR, 010 ADD, 100 AND~B, 101 OR~B, 110 SUB, 111 SLT)
- rsp_valid  out  NREQ  result pending for requester i (at most one bit set)
- rsp_ready  in  NREQ  requester i consumes its result
- rsp_y  out  32  shared result bus; valid only while any rsp_valid is set
- rsp_zero  out  1  registered ALU Zero flag for the held result

Behaviour:
- Reset (synchronous, active-high): rsp_valid=0, rsp_y=0, rsp_zero=0, owner=0, rr_ptr=0, state=IDLE.
  - req_ready is combinational and forced to 0 while reset is high.
- States:
  - IDLE: no result held.
  - HOLD: result registered, waiting for rsp_ready[owner].
- can_issue = (state==IDLE) or (state==HOLD and rsp_ready[owner]).
- Grant:
  - When can_issue, select the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Drive req_ready[i]=1 for that i in the same cycle (combinational); all other req_ready bits are 0.
  - No grant when no req_valid is set or when can_issue is 0.
- Accept (req_valid[g] & req_ready[g]) at edge t:
  - Drive the ALU from mux(g); latch Y into rsp_y and Zero into rsp_zero; set owner=g, rsp_valid[g]=1, state=HOLD.
  - rr_ptr <= (g+1) mod NREQ.
  - Latency is exactly 1 cycle: the response is visible from cycle t+1.
- Response: rsp_valid[owner], rsp_y and rsp_zero stay stable until rsp_ready[owner] is sampled high.
  - On that edge, if there is no simultaneous accept, state=IDLE and rsp_valid=0.
  - If there is a simultaneous accept, the new result replaces the old one with no bubble (back-to-back).
- rsp_ready of non-owners is ignored.
- req_valid may drop without acceptance; no state is affected and no sticky grant exists.
- Function 011 passes through to the alu unchanged; its result is whatever the alu produces.
- Zero is the ALU Zero output for the accepted operation (Y==0).
- Reset mid-HOLD discards the pending result; no response is delivered after reset.
- rr_ptr advances only on accept, never on idle cycles.

Decomposition:
- Shared package `alu_pkg`: typedef alu_op_t (logic [2:0]) and localparams ALU_AND, ALU_OR, ALU_ADD, ALU_ANDN, ALU_ORN, ALU_SUB, ALU_SLT.
- Sub-modules:
  - Instantiate the existing `alu` unchanged; do not reimplement ALU logic.
  - Natural helper: `rr_pick`, a combinational round-robin first-one finder (inputs: valid vector, ptr; outputs: grant one-hot, grant index, any).

Test Plan:
- Single request: req_valid[0]=1, a=5, b=7, f=010 -> req_ready[0]=1 in the same cycle; next cycle rsp_valid[0]=1, rsp_y=12, rsp_zero=0; rsp_ready[0]=1 -> rsp_valid=0.
- Zero flag: requester 2, a=0x1234, b=0x1234, f=110 -> rsp_y=0, rsp_zero=1. Then a=3, b=9, f=111 -> rsp_y=1, rsp_zero=0.
- Contention:
  - Stimulus: all four req_valid held high, each with a distinct ADD, rsp_ready all high.
  - Required grant order: 0,1,2,3,0,1.
  - Required timing: one accept per cycle, each rsp_y matching its requester's sum.
- Backpressure:
  - Result held for requester 1 with rsp_ready[1]=0 for 3 cycles while req_valid[3]=1 -> req_ready all 0, rsp_y stable.
  - Raising rsp_ready[1] -> req_ready[3]=1 in that cycle, rsp_valid[3] asserted the next cycle.
- Non-owner ready: rsp_valid[1] set, rsp_ready[0]=1, rsp_ready[1]=0 -> response stays held.
- Reset mid-operation:
  - Assert reset during HOLD -> next cycle rsp_valid=0, rsp_y=0, rsp_zero=0.
  - After release with req_valid[1] and req_valid[3] both set, requester 1 is granted first (rr_ptr=0).
